// File: rtl/div_nbits_seq_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
// The requester drives the master side; the divider implements the slave side.
interface div_nbits_seq_if #(
    parameter int width = 8
);
    logic             start_i;
    logic [width-1:0] a_i;
    logic [width-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [width-1:0] q_o;
    logic [width-1:0] r_o;
    logic             dbz_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, q_o, r_o, dbz_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, q_o, r_o, dbz_o
    );
endinterface

// File: rtl/div_nbits_seq.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Divide-by-zero skips iteration and reports all-ones quotient with dbz set.
module div_nbits_seq #(
    parameter int width = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    div_nbits_seq_if.slave  bus
);
    localparam int CW = $clog2(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic [width-1:0] dvd_q;
    logic [width-1:0] dvs_q;
    logic [width-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [width-1:0] q_q;
    logic [width-1:0] r_q;

    logic [width:0]   shl;
    logic [width:0]   diff;
    logic             qbit;
    logic [width-1:0] rem_d;
    logic [width-1:0] dvd_d;

    // Remainder stays below the divisor, so width bits hold it between steps.
    always_comb begin
        shl   = {rem_q, dvd_q[width-1]};
        diff  = shl - {1'b0, dvs_q};
        qbit  = ~diff[width];
        rem_d = qbit ? diff[width-1:0] : shl[width-1:0];
        dvd_d = {dvd_q[width-2:0], qbit};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        dvd_q <= bus.a_i;
                        dvs_q <= bus.b_i;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (bus.b_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            q_q     <= '1;
                            r_q     <= bus.a_i;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        q_q     <= dvd_d;
                        r_q     <= rem_d;
                        dbz_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.q_o    = q_q;
    assign bus.r_o    = r_q;
    assign bus.dbz_o  = dbz_q;
endmodule

// File: tb/tb_div_nbits_seq.sv
// Directed and random bench for div_nbits_seq with a cycle-level reference.
// Model predicts outputs from a countdown and plain / and % arithmetic.
module tb_div_nbits_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vec = 0;
    int   errs = 0;

    div_nbits_seq_if #(.width(W)) bus ();

    div_nbits_seq #(.width(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic         m_busy;
    logic         m_done;
    logic         m_dbz;
    logic [W-1:0] m_q;
    logic [W-1:0] m_r;
    logic [W-1:0] m_pq;
    logic [W-1:0] m_pr;
    int           m_left;

    // Reference: an accepted request stays busy for W edges, then reports.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_pq   <= '0;
            m_pr   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_q    <= m_pq;
                    m_r    <= m_pr;
                    m_dbz  <= 1'b0;
                end
            end else if (bus.start_i) begin
                if (bus.b_i == '0) begin
                    m_done <= 1'b1;
                    m_q    <= '1;
                    m_r    <= bus.a_i;
                    m_dbz  <= 1'b1;
                end else begin
                    m_left <= W;
                    m_busy <= 1'b1;
                    m_pq   <= bus.a_i / bus.b_i;
                    m_pr   <= bus.a_i % bus.b_i;
                end
            end
        end
    end

    task automatic compare();
        vec++;
        if ({bus.busy_o, bus.done_o, bus.dbz_o, bus.q_o, bus.r_o} !==
            {m_busy, m_done, m_dbz, m_q, m_r}) begin
            errs++;
            $display("FAIL cycle t=%0t dut b=%b d=%b z=%b q=%0d r=%0d want b=%b d=%b z=%b q=%0d r=%0d",
                     $time, bus.busy_o, bus.done_o, bus.dbz_o, bus.q_o, bus.r_o,
                     m_busy, m_done, m_dbz, m_q, m_r);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic issue(input int a, input int b);
        bus.start_i = 1'b1;
        bus.a_i     = W'(a);
        bus.b_i     = W'(b);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.a_i     = ~W'(a);
        bus.b_i     = ~W'(b);
    endtask

    task automatic wait_res(input string nm, input int c0, input int eq, input int er,
                            input int ez, input int lat);
        int c;
        c = c0;
        while (!bus.done_o && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_lat"}, c, lat);
        chk({nm, "_q"}, 32'(bus.q_o), eq);
        chk({nm, "_r"}, 32'(bus.r_o), er);
        chk({nm, "_dbz"}, 32'(bus.dbz_o), ez);
    endtask

    task automatic op(input string nm, input int a, input int b, input int eq,
                      input int er, input int ez, input int lat);
        @(negedge clk);
        issue(a, b);
        wait_res(nm, 1, eq, er, ez, lat);
    endtask

    initial begin
        int a;
        int b;
        int e0;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_q", 32'(bus.q_o), 0);
        chk("rst_r", 32'(bus.r_o), 0);
        chk("rst_dbz", 32'(bus.dbz_o), 0);
        rst = 1'b0;

        op("basic", 100, 7, 14, 2, 0, 9);
        op("e255_1", 255, 1, 255, 0, 0, 9);
        op("e5_200", 5, 200, 0, 5, 0, 9);
        op("e255_255", 255, 255, 1, 0, 0, 9);
        op("e0_9", 0, 9, 0, 0, 0, 9);
        op("dbz", 42, 0, 255, 42, 1, 1);
        op("after_dbz", 9, 3, 3, 0, 0, 9);

        @(negedge clk);
        issue(100, 7);
        repeat (3) @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 8'd50;
        bus.b_i     = 8'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_res("ignore", 5, 14, 2, 0, 9);

        issue(50, 5);
        wait_res("b2b", 1, 10, 0, 0, 9);

        @(negedge clk);
        issue(200, 3);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy_o), 0);
        chk("mid_rst_done", 32'(bus.done_o), 0);
        chk("mid_rst_q", 32'(bus.q_o), 0);
        chk("mid_rst_dbz", 32'(bus.dbz_o), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_done", 32'(bus.done_o), 0);
        end
        op("post_rst", 200, 3, 66, 2, 0, 9);

        for (int i = 0; i < 10; i++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(1, 255));
            e0 = errs;
            op("rand", a, b, a / b, a % b, 0, 9);
            $display("rand %0d: %0d/%0d -> q=%0d r=%0d %s", i, a, b,
                     bus.q_o, bus.r_o, (errs == e0) ? "ok" : "bad");
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
